// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: port indices, flit field offsets,
// and the dimension-ordered XY route function.
package noc_pkg;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        SOUTH = 3'd1,
        WEST  = 3'd2,
        EAST  = 3'd3,
        NORTH = 3'd4
    } port_e;

    localparam int unsigned NUM_PORTS = 5;

    // Control bits sit directly above the payload: {valid, head, tail, payload}
    localparam int unsigned CTRL_W    = 3;
    localparam int unsigned TAIL_OFS  = 0;
    localparam int unsigned HEAD_OFS  = 1;
    localparam int unsigned VALID_OFS = 2;

    typedef struct packed {
        logic valid;
        logic head;
        logic tail;
    } flit_hdr_t;

    function automatic port_e xy_route(input int unsigned pos_x, input int unsigned pos_y,
                                       input int unsigned dest_x, input int unsigned dest_y,
                                       input logic [NUM_PORTS-1:0] port_en);
        port_e p;
        if (dest_x > pos_x)      p = EAST;
        else if (dest_x < pos_x) p = WEST;
        else if (dest_y > pos_y) p = NORTH;
        else if (dest_y < pos_y) p = SOUTH;
        else                     p = LOCAL;
        // Off-mesh destinations are absorbed locally
        if (!port_en[p]) p = LOCAL;
        return p;
    endfunction

endpackage

// File: rtl/router_input_fifo.sv
// Per-port input buffer: circular FIFO with registered head, simultaneous
// push/pop permitted even when full. Overflowing writes are dropped.
module router_input_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned FLIT_W = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [FLIT_W-1:0]            data_i,
    output logic [FLIT_W-1:0]            head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_q, wr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/mesh_router.sv
// 5-port wormhole mesh router: input FIFOs, XY routing, per-output round-robin
// allocation with packet locking, and credit flow control towards downstream.
module mesh_router
    import noc_pkg::*;
#(
    parameter int unsigned MESH_X     = 3,
    parameter int unsigned MESH_Y     = 3,
    parameter int unsigned POS_X      = 0,
    parameter int unsigned POS_Y      = 0,
    parameter int unsigned COORD_W    = 2,
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DOWN_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_PORTS*(DATA_W+CTRL_W)-1:0]   in_flit_i,
    output logic [NUM_PORTS-1:0]                   in_credit_o,
    output logic [NUM_PORTS*(DATA_W+CTRL_W)-1:0]   out_flit_o,
    input  logic [NUM_PORTS-1:0]                   out_credit_i,
    output logic                                   local_full_o
);
    localparam int unsigned FLIT_W    = DATA_W + CTRL_W;
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned CRED_W    = $clog2(DOWN_DEPTH + 1);
    localparam int unsigned TAIL_BIT  = DATA_W + TAIL_OFS;
    localparam int unsigned HEAD_BIT  = DATA_W + HEAD_OFS;
    localparam int unsigned VALID_BIT = DATA_W + VALID_OFS;

    localparam logic [NUM_PORTS-1:0] PORT_EN = {
        (POS_Y != MESH_Y - 1),
        (POS_X != MESH_X - 1),
        (POS_X != 0),
        (POS_Y != 0),
        1'b1
    };

    logic [FLIT_W-1:0]    fifo_head [NUM_PORTS];
    logic [CNT_W-1:0]     fifo_count [NUM_PORTS];
    logic [NUM_PORTS-1:0] fifo_full, fifo_empty, push, pop;
    logic [NUM_PORTS-1:0] req_head;
    logic [2:0]           route [NUM_PORTS];

    logic [NUM_PORTS-1:0] lock_q, lock_d, move, in_credit_q, credit_ovf;
    logic [2:0]           lock_src_q [NUM_PORTS];
    logic [2:0]           lock_src_d [NUM_PORTS];
    logic [2:0]           src [NUM_PORTS];
    logic [2:0]           rr_q [NUM_PORTS];
    logic [2:0]           rr_d [NUM_PORTS];
    logic [CRED_W-1:0]    credit_q [NUM_PORTS];
    logic [CRED_W-1:0]    credit_d [NUM_PORTS];
    logic [FLIT_W-1:0]    out_q [NUM_PORTS];
    logic [FLIT_W-1:0]    out_d [NUM_PORTS];
    logic                 fifo_err;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign push[i] = PORT_EN[i] && in_flit_i[i*FLIT_W + VALID_BIT];

        router_input_fifo #(
            .DEPTH  (DEPTH),
            .FLIT_W (FLIT_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .data_i  (in_flit_i[i*FLIT_W +: FLIT_W]),
            .head_o  (fifo_head[i]),
            .count_o (fifo_count[i]),
            .full_o  (fifo_full[i]),
            .empty_o (fifo_empty[i])
        );

        assign out_flit_o[i*FLIT_W +: FLIT_W] = PORT_EN[i] ? out_q[i] : '0;
    end

    assign in_credit_o  = in_credit_q & PORT_EN;
    assign local_full_o = fifo_full[LOCAL];

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            req_head[i] = !fifo_empty[i] && fifo_head[i][HEAD_BIT];
            route[i]    = xy_route(POS_X, POS_Y,
                                   32'(fifo_head[i][COORD_W-1:0]),
                                   32'(fifo_head[i][2*COORD_W-1:COORD_W]), PORT_EN);
        end
    end

    // Lock, grant and credit updates are folded into one pass per output:
    // a grant only happens when a credit is available, so grant implies traversal.
    always_comb begin
        int unsigned idx;
        logic        inc;
        idx        = 0;
        inc        = 1'b0;
        lock_d     = lock_q;
        pop        = '0;
        move       = '0;
        credit_ovf = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            lock_src_d[o] = lock_src_q[o];
            rr_d[o]       = rr_q[o];
            credit_d[o]   = credit_q[o];
            out_d[o]      = '0;
            src[o]        = lock_src_q[o];
            if (PORT_EN[o] && credit_q[o] != '0) begin
                if (lock_q[o]) begin
                    move[o] = !fifo_empty[lock_src_q[o]];
                end else begin
                    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                        idx = (32'(rr_q[o]) + k) % NUM_PORTS;
                        if (!move[o] && req_head[idx] && route[idx] == 3'(o)) begin
                            move[o] = 1'b1;
                            src[o]  = 3'(idx);
                            rr_d[o] = 3'((idx + 1) % NUM_PORTS);
                        end
                    end
                end
            end
            if (move[o]) begin
                pop[src[o]]   = 1'b1;
                out_d[o]      = fifo_head[src[o]];
                lock_d[o]     = !fifo_head[src[o]][TAIL_BIT];
                lock_src_d[o] = src[o];
            end
            inc = out_credit_i[o] && PORT_EN[o];
            if (inc && !move[o]) begin
                if (credit_q[o] == CRED_W'(DOWN_DEPTH)) credit_ovf[o] = 1'b1;
                else                                    credit_d[o] = credit_q[o] + 1'b1;
            end else if (!inc && move[o]) begin
                credit_d[o] = credit_q[o] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q      <= '0;
            in_credit_q <= '0;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                lock_src_q[o] <= '0;
                rr_q[o]       <= '0;
                credit_q[o]   <= CRED_W'(DOWN_DEPTH);
                out_q[o]      <= '0;
            end
        end else begin
            lock_q      <= lock_d;
            in_credit_q <= pop;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                lock_src_q[o] <= lock_src_d[o];
                rr_q[o]       <= rr_d[o];
                credit_q[o]   <= credit_d[o];
                out_q[o]      <= out_d[o];
            end
        end
    end

    always_comb begin
        fifo_err = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if ((push[i] && fifo_full[i] && !pop[i]) || (pop[i] && fifo_empty[i]) ||
                (fifo_full[i] != (fifo_count[i] == CNT_W'(DEPTH))))
                fifo_err = 1'b1;
        end
    end

    a_fifo_ok:   assert property (@(posedge clk) disable iff (rst) !fifo_err);
    a_credit_ok: assert property (@(posedge clk) disable iff (rst) credit_ovf == '0);

endmodule

// File: tb/tb_mesh_router.sv
// Scoreboard bench for mesh_router: three instances at (1,1), (0,0) and (2,2)
// of a 3x3 mesh, with a downstream model that returns credits on demand.
module tb_mesh_router;
    localparam int DW = 14;
    localparam int FW = DW + 3;
    localparam int ND = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [5*FW-1:0] in_flit    [ND];
    logic [5*FW-1:0] out_flit   [ND];
    logic [4:0]      in_credit  [ND];
    logic [4:0]      out_credit [ND];
    logic [4:0]      man_credit [ND];
    logic            local_full [ND];
    logic            auto_cr = 1'b1;

    logic [FW-1:0] exp_q [ND*5][$];
    int            emitted [ND*5];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    function automatic logic [4:0] vbits(input logic [5*FW-1:0] f);
        logic [4:0] v;
        for (int p = 0; p < 5; p++) v[p] = f[p*FW + FW - 1];
        return v;
    endfunction

    for (genvar d = 0; d < ND; d++) begin : g_cr
        assign out_credit[d] = (auto_cr ? vbits(out_flit[d]) : 5'b0) | man_credit[d];
    end

    mesh_router #(.MESH_X(3), .MESH_Y(3), .POS_X(1), .POS_Y(1), .COORD_W(2),
                  .DATA_W(DW), .DEPTH(4), .DOWN_DEPTH(4)) dut_11 (
        .clk(clk), .rst(rst), .in_flit_i(in_flit[0]), .in_credit_o(in_credit[0]),
        .out_flit_o(out_flit[0]), .out_credit_i(out_credit[0]), .local_full_o(local_full[0]));
    mesh_router #(.MESH_X(3), .MESH_Y(3), .POS_X(0), .POS_Y(0), .COORD_W(2),
                  .DATA_W(DW), .DEPTH(4), .DOWN_DEPTH(4)) dut_00 (
        .clk(clk), .rst(rst), .in_flit_i(in_flit[1]), .in_credit_o(in_credit[1]),
        .out_flit_o(out_flit[1]), .out_credit_i(out_credit[1]), .local_full_o(local_full[1]));
    mesh_router #(.MESH_X(3), .MESH_Y(3), .POS_X(2), .POS_Y(2), .COORD_W(2),
                  .DATA_W(DW), .DEPTH(4), .DOWN_DEPTH(4)) dut_22 (
        .clk(clk), .rst(rst), .in_flit_i(in_flit[2]), .in_credit_o(in_credit[2]),
        .out_flit_o(out_flit[2]), .out_credit_i(out_credit[2]), .local_full_o(local_full[2]));

    function automatic logic [FW-1:0] mk(input logic h, input logic t, input logic [DW-1:0] pl);
        return {1'b1, h, t, pl};
    endfunction

    function automatic logic [DW-1:0] hp(input int x, input int y, input int tag);
        logic [DW-1:0] v;
        v      = DW'(tag) << 4;
        v[1:0] = x[1:0];
        v[3:2] = y[1:0];
        return v;
    endfunction

    // Scoreboard monitor: every valid output flit must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < ND; d++) begin
                for (int p = 0; p < 5; p++) begin
                    logic [FW-1:0] f, e;
                    f = out_flit[d][p*FW +: FW];
                    if (f[FW-1]) begin
                        emitted[d*5+p]++;
                        checks++;
                        if (exp_q[d*5+p].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_flit dut%0d port%0d got %h required none", d, p, f);
                        end else begin
                            e = exp_q[d*5+p].pop_front();
                            if (f !== e) begin
                                errors++;
                                $display("FAIL flit_data dut%0d port%0d got %h required %h", d, p, f, e);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < ND; d++) begin
            in_flit[d]    = '0;
            man_credit[d] = '0;
        end
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1;
        clear_inputs();
        for (int q = 0; q < ND*5; q++) exp_q[q].delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int  n;
        bit  empty;
        empty = 1'b0;
        for (n = 0; n < 60; n++) begin
            empty = 1'b1;
            for (int q = 0; q < ND*5; q++) if (exp_q[q].size() != 0) empty = 1'b0;
            if (empty) break;
            @(negedge clk);
        end
        checks++;
        if (!empty) begin
            errors++;
            $display("FAIL %s_drain got flits pending after %0d cycles required all delivered", name, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) tick();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (out_flit[d] !== '0 || in_credit[d] !== 5'b0 || local_full[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got out=%h cr=%b full=%b required all 0",
                         d, out_flit[d], in_credit[d], local_full[d]);
            end
        end
        for (int o = 0; o < 5; o++) begin
            checks++;
            if (dut_11.credit_q[o] !== 3'd4) begin
                errors++;
                $display("FAIL reset_credit port%0d got %0d required 4", o, dut_11.credit_q[o]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [FW-1:0] f;
        f = mk(1'b1, 1'b1, hp(2, 1, 'h155));
        tick();
        in_flit[0][0 +: FW] = f;
        exp_q[3].push_back(f);
        tick();
        in_flit[0] = '0;
        @(negedge clk);
        checks++;
        if (out_flit[0][3*FW + FW-1] !== 1'b0 || in_credit[0] !== 5'b0) begin
            errors++;
            $display("FAIL single_early got valid=%b cr=%b required 0 0",
                     out_flit[0][3*FW + FW-1], in_credit[0]);
        end
        @(negedge clk);
        checks++;
        if (out_flit[0][3*FW +: FW] !== f) begin
            errors++;
            $display("FAIL single_latency got %h required %h", out_flit[0][3*FW +: FW], f);
        end
        checks++;
        if (in_credit[0] !== 5'b00001) begin
            errors++;
            $display("FAIL single_in_credit got %b required 00001", in_credit[0]);
        end
        checks++;
        if (dut_11.credit_q[3] !== 3'd3) begin
            errors++;
            $display("FAIL single_east_credit got %0d required 3", dut_11.credit_q[3]);
        end
        wait_drain("single");
    endtask

    task automatic test_xy_order();
        logic [FW-1:0] fw, fl;
        int            w0, n0;
        w0 = emitted[2];
        n0 = emitted[4];
        fw = mk(1'b1, 1'b1, hp(0, 2, 'h2a));
        fl = mk(1'b1, 1'b1, hp(1, 1, 'h3c));
        exp_q[2].push_back(fw);
        exp_q[0].push_back(fl);
        tick(); in_flit[0][0 +: FW] = fw;
        tick(); in_flit[0][0 +: FW] = fl;
        tick(); in_flit[0] = '0;
        wait_drain("xy");
        checks++;
        if (emitted[2] - w0 !== 1 || emitted[4] - n0 !== 0) begin
            errors++;
            $display("FAIL xy_west_first got west=%0d north=%0d required 1 0",
                     emitted[2] - w0, emitted[4] - n0);
        end
    endtask

    task automatic test_round_robin();
        logic [FW-1:0] wf [3];
        logic [FW-1:0] ef [3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wf[i] = mk(i == 0, i == 2, (i == 0) ? hp(1, 1, 'h10) : DW'('h1000 + i));
            ef[i] = mk(i == 0, i == 2, (i == 0) ? hp(1, 1, 'h20) : DW'('h2000 + i));
        end
        for (int i = 0; i < 3; i++) exp_q[0].push_back(wf[i]);
        for (int i = 0; i < 3; i++) exp_q[0].push_back(ef[i]);
        for (int i = 0; i < 3; i++) begin
            tick();
            in_flit[0][2*FW +: FW] = wf[i];
            in_flit[0][3*FW +: FW] = ef[i];
        end
        tick();
        in_flit[0] = '0;
        wait_drain("rr");
        checks++;
        if (dut_11.rr_q[0] !== 3'd4) begin
            errors++;
            $display("FAIL rr_pointer got %0d required 4", dut_11.rr_q[0]);
        end
    endtask

    task automatic test_credit_stall();
        int e0;
        do_reset();
        auto_cr = 1'b0;
        e0 = emitted[3];
        for (int i = 0; i < 8; i++) begin
            logic [FW-1:0] f;
            f = mk(i == 0, i == 7, (i == 0) ? hp(2, 1, 'h77) : DW'('h0700 + i));
            exp_q[3].push_back(f);
            tick();
            in_flit[0][0 +: FW] = f;
        end
        tick();
        in_flit[0] = '0;
        repeat (6) @(negedge clk);
        checks++;
        if (emitted[3] - e0 !== 4) begin
            errors++;
            $display("FAIL stall_count got %0d required 4", emitted[3] - e0);
        end
        checks++;
        if (local_full[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_full got %b required 1", local_full[0]);
        end
        tick(); man_credit[0] = 5'b01000;
        tick(); man_credit[0] = 5'b00000;
        repeat (5) @(negedge clk);
        checks++;
        if (emitted[3] - e0 !== 5) begin
            errors++;
            $display("FAIL stall_one_more got %0d required 5", emitted[3] - e0);
        end
        checks++;
        if (local_full[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_unfull got %b required 0", local_full[0]);
        end
        auto_cr = 1'b1;
        do_reset();
    endtask

    task automatic test_edges();
        for (int n = 0; n < 16; n++) begin
            tick();
            clear_inputs();
            if (n == 0) begin
                in_flit[1][0 +: FW]    = mk(1'b1, 1'b1, hp(3, 3, 'h31));
                exp_q[5+3].push_back(in_flit[1][0 +: FW]);
                in_flit[1][2*FW +: FW] = mk(1'b1, 1'b1, hp(2, 2, 'h3f));
                in_flit[2][0 +: FW]    = mk(1'b1, 1'b1, hp(3, 1, 'h32));
                exp_q[10+0].push_back(in_flit[2][0 +: FW]);
            end else if (n == 1) begin
                in_flit[1][0 +: FW]    = mk(1'b1, 1'b1, hp(0, 0, 'h33));
                exp_q[5+0].push_back(in_flit[1][0 +: FW]);
                in_flit[1][1*FW +: FW] = mk(1'b1, 1'b1, hp(1, 0, 'h3e));
                in_flit[2][0 +: FW]    = mk(1'b1, 1'b1, hp(2, 3, 'h34));
                exp_q[10+0].push_back(in_flit[2][0 +: FW]);
            end
            @(negedge clk);
            checks++;
            if (out_flit[1][1*FW +: 2*FW] !== '0 || in_credit[1][2:1] !== 2'b00 ||
                out_flit[2][3*FW +: 2*FW] !== '0 || in_credit[2][4:3] !== 2'b00) begin
                errors++;
                $display("FAIL disabled_ports cycle %0d got %h %b %h %b required all 0", n,
                         out_flit[1][1*FW +: 2*FW], in_credit[1][2:1],
                         out_flit[2][3*FW +: 2*FW], in_credit[2][4:3]);
            end
        end
        wait_drain("edges");
    endtask

    task automatic test_reset_mid_packet();
        logic [FW-1:0] h, b;
        int            e0;
        h = mk(1'b1, 1'b0, hp(2, 1, 'h66));
        b = mk(1'b0, 1'b0, DW'('h0666));
        exp_q[3].push_back(h);
        tick(); in_flit[0][0 +: FW] = h;
        tick(); in_flit[0][0 +: FW] = b;
        tick(); in_flit[0] = '0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_flit[0] !== '0 || in_credit[0] !== 5'b0 || local_full[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got out=%h cr=%b required 0", out_flit[0], in_credit[0]);
        end
        checks++;
        if (dut_11.credit_q[3] !== 3'd4) begin
            errors++;
            $display("FAIL midreset_credit got %0d required 4", dut_11.credit_q[3]);
        end
        for (int q = 0; q < ND*5; q++) exp_q[q].delete();
        repeat (2) tick();
        rst = 1'b0;
        e0 = emitted[3];
        repeat (10) @(negedge clk);
        checks++;
        if (emitted[3] !== e0) begin
            errors++;
            $display("FAIL midreset_residual got %0d flits required 0", emitted[3] - e0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int q = 0; q < ND*5; q++) emitted[q] = 0;
        test_reset();
        test_single();
        test_xy_order();
        test_round_robin();
        test_credit_stall();
        test_edges();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
